spu64_sram_eval_core: RTL and testbench
=======================================

Name: spu64_sram_eval_core

Overview:
- Single-clock evaluation block with a 64-bit Wishbone slave, four 1024x64 SRAM banks and an SRAM-to-SRAM compute engine.
- Host loads source banks MEM0/MEM1, writes START, polls DONE, then reads result banks MEM2/MEM3.
- The engine computes per-byte-lane sum (MEM2) and difference (MEM3) of MEM0 and MEM1.
- Sits behind the host Wishbone interconnect as a memory-mapped peripheral.

Parameters:
- WB_ADR_WIDTH, 37, Wishbone word-address width; only bits [12:0] are decoded.
- WB_DAT_WIDTH, 64, Wishbone data width; the design supports only 64.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width (derived).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_wb_adr_i  input  WB_ADR_WIDTH  word address.
- s_wb_dat_i  input  WB_DAT_WIDTH  write data.
- s_wb_dat_o  output  WB_DAT_WIDTH  read data, valid while s_wb_ack_o=1.
- s_wb_sel_i  input  WB_SEL_WIDTH  byte enables; bit n covers bits [8n+7:8n].
- s_wb_we_i  input  1  1=write, 0=read.
- s_wb_stb_i  input  1  access request.
- s_wb_ack_o  output  1  one-cycle access acknowledge.

Behaviour:
- Address decode on adr[12:0]; upper bits ignored (aliasing).
  - adr[12]=0: register space, register index adr[3:0].
  - adr[12]=1: memory space, bank = adr[11:10] (0x1000 MEM0, 0x1400 MEM1, 0x1800 MEM2, 0x1C00 MEM3), word = adr[9:0].
- Handshake:
  - ack is registered: ack(next) = stb & !ack. Every access gives exactly one ack pulse one cycle after stb is sampled.
  - The master holds adr/dat/sel/we until ack and drops stb after it.
  - Writes commit on the first stb cycle (stb & !ack), so each write commits exactly once.
  - Read data is presented with ack (synchronous SRAM read, 1-cycle latency).
- Byte enables apply to memory writes; unselected bytes are preserved.
  - Example: eight single-lane writes to MEM1[1] with sel 0x01..0x80 merge to 0x8877665544332211.
- Registers (64-bit):
  - 0 CTRL: write with dat[0]=1 starts the engine if idle; ignored while busy. Read returns {63'b0, busy}.
  - 1 STATUS: read returns {63'b0, done}. done is sticky, set when the engine finishes; any write clears it.
  - 2 SIZE: read-only, returns 1024.
  - Other indices read 0; writes to them are ignored. Register writes ignore sel (full-word).
- Engine:
  - States IDLE -> RUN -> FLUSH -> IDLE.
  - START: clears done, sets busy, index i=0.
  - RUN: issue read of MEM0[i] and MEM1[i] on second SRAM ports, i increments each cycle through 1023.
  - Two-stage pipeline (read, compute/write). For each byte lane k (mod 256):
    - MEM2[i].byte k = MEM0[i].byte k + MEM1[i].byte k
    - MEM3[i].byte k = MEM0[i].byte k - MEM1[i].byte k
  - FLUSH: drains the pipeline. After the write of index 1023: busy=0, done=1, back to IDLE.
  - Start-to-done is 1024+3 cycles ±1.
- Each bank is true dual port: port A Wishbone, port B engine (read for MEM0/MEM1, write for MEM2/MEM3).
  - Wishbone access to any bank is legal while busy.
  - Wishbone writes to MEM0/MEM1 while busy give undefined results for indices not yet processed.
  - Wishbone reads of MEM2/MEM3 while busy may return old or new data.
  - Simultaneous Wishbone write and engine write to the same MEM2/MEM3 word: engine wins.
- Reset: ack=0, dat_o=0, busy=0, done=0, state IDLE, i=0.
  - Reset mid-run aborts immediately; partially written MEM2/MEM3 contents remain.
  - Memory contents are not cleared by reset.
- The index wraps only via termination at 1023; no engine access beyond 1023.

Test Plan:
- Write MEM0[0..9] = 0x0706050403020100 .. 0x4f4e4d4c4b4a4948 with sel=0xff, read back -> identical values; each access acked exactly one cycle after stb.
- Eight byte-lane writes to MEM1[1] (sel 0x01..0x80, data byte n = 0x11*(n+1), other bytes 0x99) -> read 0x8877665544332211. Write MEM2[0]=0x3333, MEM3[0]=0x4444 -> read back exactly.
- Fill MEM0 with 0x0101010101010101 and MEM1 with 0x0202020202020202 for all 1024 words, write CTRL=1, poll STATUS -> done=1 within ~1030 cycles. Every MEM2 word reads 0x0303030303030303; every MEM3 word reads 0xFFFFFFFFFFFFFFFF.
- Lane-carry isolation: MEM0[5]=0x00000000000000FF, MEM1[5]=0x0000000000000001 -> MEM2[5]=0x0000000000000000, MEM3[5]=0x00000000000000FE.
- Write STATUS=0 -> reads 0. Write CTRL=1 twice during a run -> second write ignored, single done. CTRL reads 1 while busy, 0 after.
- Assert reset mid-run -> busy=0, done=0, ack=0. A new START then completes normally with correct results.

Source files
------------

// File: rtl/spu64_sram_eval_core.sv
// Wishbone-mapped evaluation core: four 1024x64 dual-port SRAM banks and an
// engine that writes the per-byte sum (MEM2) and difference (MEM3) of MEM0/MEM1.
module spu64_sram_eval_core #(
   parameter int unsigned WB_ADR_WIDTH = 37,
   parameter int unsigned WB_DAT_WIDTH = 64,
   parameter int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
   input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
   input  logic                    s_wb_we_i,
   input  logic                    s_wb_stb_i,
   output logic                    s_wb_ack_o
);

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned IDX_W = 10;
   localparam int unsigned LANES = WB_SEL_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   logic [WB_DAT_WIDTH-1:0] mem0 [DEPTH];
   logic [WB_DAT_WIDTH-1:0] mem1 [DEPTH];
   logic [WB_DAT_WIDTH-1:0] mem2 [DEPTH];
   logic [WB_DAT_WIDTH-1:0] mem3 [DEPTH];

   state_t                  state, state_nxt;
   logic                    rd_en, finish;
   logic                    busy, done;
   logic [IDX_W-1:0]        rd_idx, wr_idx;
   logic                    wr_vld;
   logic [WB_DAT_WIDTH-1:0] eng_a, eng_b, eng_sum, eng_diff;
   logic                    eng_we;

   // Host-side decode; only adr[12:0] is significant, the rest aliases.
   logic                    wb_access, wb_wr, wb_rd;
   logic                    is_mem;
   logic [1:0]              bank;
   logic [IDX_W-1:0]        word;
   logic [3:0]              reg_idx;
   logic [3:0]              mem_we;
   logic                    start, status_clr;
   logic [WB_DAT_WIDTH-1:0] reg_rdata;
   logic                    adr_unused;

   assign wb_access  = s_wb_stb_i & ~s_wb_ack_o;
   assign wb_wr      = wb_access & s_wb_we_i;
   assign wb_rd      = wb_access & ~s_wb_we_i;
   assign is_mem     = s_wb_adr_i[12];
   assign bank       = s_wb_adr_i[11:10];
   assign word       = s_wb_adr_i[9:0];
   assign reg_idx    = s_wb_adr_i[3:0];
   assign adr_unused = ^s_wb_adr_i[WB_ADR_WIDTH-1:13];

   always_comb begin
      mem_we = '0;
      if (wb_wr && is_mem) mem_we[bank] = 1'b1;
   end

   assign busy       = (state != IDLE);
   assign start      = wb_wr & ~is_mem & (reg_idx == 4'd0) & s_wb_dat_i[0] & ~busy;
   assign status_clr = wb_wr & ~is_mem & (reg_idx == 4'd1);

   always_comb begin
      reg_rdata = '0;
      case (reg_idx)
         4'd0:    reg_rdata = WB_DAT_WIDTH'(busy);
         4'd1:    reg_rdata = WB_DAT_WIDTH'(done);
         4'd2:    reg_rdata = WB_DAT_WIDTH'(DEPTH);
         default: reg_rdata = '0;
      endcase
   end

   // Engine FSM: state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Engine FSM: next state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (rd_idx == LAST_IDX) state_nxt = FLUSH;
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Engine FSM: outputs. FLUSH is the cycle that writes the last index.
   always_comb begin
      rd_en  = 1'b0;
      finish = 1'b0;
      case (state)
         RUN:     rd_en  = 1'b1;
         FLUSH:   finish = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_idx <= '0;
         wr_vld <= 1'b0;
         done   <= 1'b0;
      end else begin
         wr_vld <= rd_en;
         if (start)      rd_idx <= '0;
         else if (rd_en) rd_idx <= rd_idx + IDX_W'(1);
         if (finish)                  done <= 1'b1;
         else if (start | status_clr) done <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) wr_idx <= rd_idx;
   end

   // Lane-wise arithmetic; carries never cross byte boundaries.
   always_comb begin
      eng_sum  = '0;
      eng_diff = '0;
      for (int k = 0; k < LANES; k++) begin
         eng_sum[8*k +: 8]  = eng_a[8*k +: 8] + eng_b[8*k +: 8];
         eng_diff[8*k +: 8] = eng_a[8*k +: 8] - eng_b[8*k +: 8];
      end
   end

   assign eng_we = wr_vld & ~reset;

   // Source banks: port A host byte writes, port B engine read.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (mem_we[0] && s_wb_sel_i[k]) mem0[word][8*k +: 8] <= s_wb_dat_i[8*k +: 8];
         if (mem_we[1] && s_wb_sel_i[k]) mem1[word][8*k +: 8] <= s_wb_dat_i[8*k +: 8];
      end
      if (rd_en) begin
         eng_a <= mem0[rd_idx];
         eng_b <= mem1[rd_idx];
      end
   end

   // Result banks: the engine write is issued last so it wins on a collision.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (mem_we[2] && s_wb_sel_i[k]) mem2[word][8*k +: 8] <= s_wb_dat_i[8*k +: 8];
         if (mem_we[3] && s_wb_sel_i[k]) mem3[word][8*k +: 8] <= s_wb_dat_i[8*k +: 8];
      end
      if (eng_we) begin
         mem2[wr_idx] <= eng_sum;
         mem3[wr_idx] <= eng_diff;
      end
   end

   // Registered acknowledge and read data; dat_o is zero outside ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_wb_ack_o <= 1'b0;
         s_wb_dat_o <= '0;
      end else begin
         s_wb_ack_o <= wb_access;
         s_wb_dat_o <= '0;
         if (wb_rd) begin
            if (is_mem) begin
               case (bank)
                  2'd0:    s_wb_dat_o <= mem0[word];
                  2'd1:    s_wb_dat_o <= mem1[word];
                  2'd2:    s_wb_dat_o <= mem2[word];
                  default: s_wb_dat_o <= mem3[word];
               endcase
            end else begin
               s_wb_dat_o <= reg_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_spu64_sram_eval_core.sv
// Scoreboard bench for spu64_sram_eval_core: host accesses, engine runs,
// lane isolation, register semantics and mid-run reset.
module tb_spu64_sram_eval_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [36:0] adr;
   logic [63:0] dat_i, dat_o;
   logic [7:0]  sel;
   logic        we, stb, ack;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [63:0] m0 [1024];
   logic [63:0] m1 [1024];
   logic [63:0] exp_q [$];

   localparam logic [36:0] REG_CTRL   = 37'h0;
   localparam logic [36:0] REG_STATUS = 37'h1;
   localparam logic [36:0] REG_SIZE   = 37'h2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   spu64_sram_eval_core dut (
      .clk        (clk),
      .reset      (reset),
      .s_wb_adr_i (adr),
      .s_wb_dat_i (dat_i),
      .s_wb_dat_o (dat_o),
      .s_wb_sel_i (sel),
      .s_wb_we_i  (we),
      .s_wb_stb_i (stb),
      .s_wb_ack_o (ack)
   );

   function automatic logic [36:0] madr(input int bank, input int word);
      return 37'(32'h1000 + bank * 1024 + word);
   endfunction

   function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
      return r;
   endfunction

   function automatic logic [63:0] lane_sub(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = a[8*k +: 8] - b[8*k +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // One Wishbone access; ack must arrive exactly one cycle after stb.
   task automatic wb_cycle(input logic [36:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic w, output logic [63:0] r);
      @(posedge clk); #1;
      adr = a; dat_i = d; sel = s; we = w; stb = 1'b1;
      @(posedge clk); #1;
      check($sformatf("ack_latency@%h", a), 64'(ack), 64'd1);
      r = dat_o;
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [36:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] r;
      wb_cycle(a, d, s, 1'b1, r);
   endtask

   task automatic rd(input string tag, input logic [36:0] a, input logic [63:0] e);
      logic [63:0] r;
      exp_q.push_back(e);
      wb_cycle(a, 64'h0, 8'hff, 1'b0, r);
      check(tag, r, exp_q.pop_front());
   endtask

   // Poll STATUS until done; return the cycle of the ack that showed it.
   task automatic poll_done(output int t);
      logic [63:0] r;
      t = -1;
      for (int p = 0; p < 700; p++) begin
         wb_cycle(REG_STATUS, 64'h0, 8'hff, 1'b0, r);
         if (r[0]) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_all(input int w);
      rd($sformatf("mem2[%0d]", w), madr(2, w), lane_add(m0[w], m1[w]));
      rd($sformatf("mem3[%0d]", w), madr(3, w), lane_sub(m0[w], m1[w]));
   endtask

   initial begin
      int          t0, t1;
      logic [63:0] d;

      reset = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_dat", dat_o, 64'd0);
      rd("ctrl_rst", REG_CTRL, 64'd0);
      rd("status_rst", REG_STATUS, 64'd0);
      rd("size", REG_SIZE, 64'd1024);
      rd("reg5", 37'h5, 64'd0);

      // Full-word writes and readback
      for (int i = 0; i < 10; i++) begin
         m0[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
         wr(madr(0, i), m0[i], 8'hff);
      end
      for (int i = 0; i < 10; i++) rd($sformatf("mem0[%0d]", i), madr(0, i), m0[i]);
      rd("alias", 37'h10_0000_1003, 64'h1f1e1d1c1b1a1918);

      // Byte-lane merge
      wr(madr(1, 1), 64'h0, 8'hff);
      for (int n = 0; n < 8; n++) begin
         d = {8{8'h99}};
         d[8*n +: 8] = 8'(8'h11 * (n + 1));
         wr(madr(1, 1), d, 8'(1 << n));
      end
      rd("bytemerge", madr(1, 1), 64'h8877665544332211);
      wr(madr(2, 0), 64'h3333, 8'hff);
      wr(madr(3, 0), 64'h4444, 8'hff);
      rd("mem2_host", madr(2, 0), 64'h3333);
      rd("mem3_host", madr(3, 0), 64'h4444);

      // Full engine run, with a lane-carry word at index 5
      for (int w = 0; w < 1024; w++) begin
         m0[w] = (w == 5) ? 64'h00000000000000FF : 64'h0101010101010101;
         m1[w] = (w == 5) ? 64'h0000000000000001 : 64'h0202020202020202;
         wr(madr(0, w), m0[w], 8'hff);
         wr(madr(1, w), m1[w], 8'hff);
      end
      wr(REG_CTRL, 64'd1, 8'hff);
      t0 = cyc;
      rd("ctrl_busy", REG_CTRL, 64'd1);
      wr(REG_CTRL, 64'd1, 8'hff);
      poll_done(t1);
      check("run_length_ok", 64'((t1 - t0 >= 1024) && (t1 - t0 <= 1029)), 64'd1);
      rd("status_sticky", REG_STATUS, 64'd1);
      rd("ctrl_idle", REG_CTRL, 64'd0);
      for (int w = 0; w < 1024; w++) check_all(w);
      rd("mem2_allones", madr(2, 100), 64'h0303030303030303);
      rd("mem3_allones", madr(3, 100), 64'hFFFFFFFFFFFFFFFF);
      rd("carry_sum", madr(2, 5), 64'h0);
      rd("carry_diff", madr(3, 5), 64'hFE);
      wr(REG_STATUS, 64'd0, 8'hff);
      rd("status_clr", REG_STATUS, 64'd0);

      // Mid-run reset, then a clean rerun with changed sources
      m0[7] = 64'h1020304050607080;
      m1[7] = 64'h0102030405060708;
      wr(madr(0, 7), m0[7], 8'hff);
      wr(madr(1, 7), m1[7], 8'hff);
      wr(madr(2, 7), 64'hDEADBEEF, 8'hff);
      wr(madr(2, 1023), 64'hDEADBEEF, 8'hff);
      wr(madr(3, 1023), 64'hDEADBEEF, 8'hff);
      wr(REG_CTRL, 64'd1, 8'hff);
      repeat (200) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_ack", 64'(ack), 64'd0);
      check("midrst_dat", dat_o, 64'd0);
      rd("midrst_busy", REG_CTRL, 64'd0);
      rd("midrst_done", REG_STATUS, 64'd0);
      wr(REG_CTRL, 64'd1, 8'hff);
      t0 = cyc;
      poll_done(t1);
      check("rerun_length_ok", 64'((t1 - t0 >= 1024) && (t1 - t0 <= 1029)), 64'd1);
      check_all(0);
      check_all(5);
      check_all(7);
      check_all(1023);
      rd("rerun_sum7", madr(2, 7), 64'h1122334455667788);
      rd("rerun_diff7", madr(3, 7), 64'h0F1E2D3C4B5A6978);
      rd("ctrl_final", REG_CTRL, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1);
   end

endmodule
